// File: rtl/bus_arbiter_pkg.sv
// Shared bus constants: arbiter state encoding, slave address map, M1 hold limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  // Arbiter ownership states; exactly one master owns the bus at any time.
  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } arb_state_t;

  // Registered read-select encoding, laid out as {S1_sel, S0_sel}.
  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_S0   = 2'b01,
    RD_S1   = 2'b10
  } rd_sel_t;

  // Slave address map: S0 at [S0_BASE, S1_BASE), S1 at [S1_BASE, UNMAPPED_BASE),
  // everything from UNMAPPED_BASE upward selects nothing.
  localparam logic [7:0] S0_BASE       = 8'h00;
  localparam logic [7:0] S1_BASE       = 8'h20;
  localparam logic [7:0] UNMAPPED_BASE = 8'h40;

  // Contended M1 cycles tolerated before M0 takes the bus back (counter value 0..15).
  localparam logic [3:0] HOLD_LIMIT = 4'd15;

endpackage

// File: rtl/bus_decoder.sv
// Address decoder: maps the granted master's address to a single slave select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; selects drop whenever req is low.
module bus_decoder
  import bus_arbiter_pkg::*;
(
  input  logic [7:0] address,
  input  logic       req,
  output logic       S0_sel,
  output logic       S1_sel
);

  // Offsets from each window base keep the compares unsigned and free of wrap.
  logic [7:0] s0_off;
  logic [7:0] s1_off;

  assign s0_off = address - S0_BASE;
  assign s1_off = address - S1_BASE;

  // Windows are disjoint, so at most one select can be high.
  always_comb begin
    S0_sel = req && (s0_off < (S1_BASE - S0_BASE));
    S1_sel = req && (address >= S1_BASE) && (s1_off < (UNMAPPED_BASE - S1_BASE));
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, two-slave bus arbiter with M0 priority and bounded M1 tenure.
// Latency: grant changes one cycle after the request is sampled; read data one cycle after the access.
// Backpressure: none; a master simply keeps req high until it sees its grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  input  logic [31:0] S0_dout,
  input  logic [31:0] S1_dout,
  output logic        M0_grant,
  output logic        M1_grant,
  output logic        S0_sel,
  output logic        S1_sel,
  output logic [7:0]  S_address,
  output logic        S_wr,
  output logic [31:0] S_din,
  output logic [31:0] M_din
);

  arb_state_t state;
  logic [3:0] hold_cnt;
  rd_sel_t    rd_sel;
  logic       gnt_req;

  // Grants come straight off the state register, so there is no request-to-grant path.
  assign M0_grant = (state == M0_GRANT);
  assign M1_grant = (state == M1_GRANT);

  // Forward the owning master's request fields to the slave side.
  always_comb begin
    if (state == M1_GRANT) begin
      gnt_req   = M1_req;
      S_address = M1_address;
      S_wr      = M1_wr & M1_req;
      S_din     = M1_dout;
    end else begin
      gnt_req   = M0_req;
      S_address = M0_address;
      S_wr      = M0_wr & M0_req;
      S_din     = M0_dout;
    end
  end

  bus_decoder u_bus_decoder (
    .address (S_address),
    .req     (gnt_req),
    .S0_sel  (S0_sel),
    .S1_sel  (S1_sel)
  );

  // Ownership FSM: M0 keeps the bus unless idle while M1 asks; M1 yields when idle or after its hold budget.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= M0_GRANT;
      hold_cnt <= '0;
    end else begin
      case (state)
        M0_GRANT: begin
          // Counter sits at zero here so M1 always starts its tenure with a fresh budget.
          hold_cnt <= '0;
          if (!M0_req && M1_req) begin
            state <= M1_GRANT;
          end
        end
        M1_GRANT: begin
          if (!M1_req || (M0_req && (hold_cnt == HOLD_LIMIT))) begin
            state    <= M0_GRANT;
            hold_cnt <= '0;
          end else if (M0_req && (hold_cnt != HOLD_LIMIT)) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Remember which slave a read addressed so its data can be steered back next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_sel <= RD_NONE;
    end else if (S_wr) begin
      rd_sel <= RD_NONE;
    end else begin
      rd_sel <= rd_sel_t'({S1_sel, S0_sel});
    end
  end

  // Return read data to both masters; writes and unmapped reads return zero.
  always_comb begin
    case (rd_sel)
      RD_S0:   M_din = S0_dout;
      RD_S1:   M_din = S1_dout;
      default: M_din = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: ownership/read model plus directed scenarios.
// Latency: inputs change 1 time unit after posedge; outputs checked mid-cycle and at negedge.
// Backpressure: n/a.
module tb_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout, S0_dout, S1_dout;
  logic        M0_grant, M1_grant, S0_sel, S1_sel, S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din, M_din;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .M0_req     (M0_req),
    .M0_wr      (M0_wr),
    .M0_address (M0_address),
    .M0_dout    (M0_dout),
    .M1_req     (M1_req),
    .M1_wr      (M1_wr),
    .M1_address (M1_address),
    .M1_dout    (M1_dout),
    .S0_dout    (S0_dout),
    .S1_dout    (S1_dout),
    .M0_grant   (M0_grant),
    .M1_grant   (M1_grant),
    .S0_sel     (S0_sel),
    .S1_sel     (S1_sel),
    .S_address  (S_address),
    .S_wr       (S_wr),
    .S_din      (S_din),
    .M_din      (M_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map from the bus description: 0 = slave 0, 1 = slave 1, -1 = nobody.
  function automatic int region(input logic [7:0] a);
    if (a < 8'h20) return 0;
    if (a < 8'h40) return 1;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  int m_owner   = 0;   // which master owns the bus
  int m_contend = 0;   // cycles M0 has been asking while M1 owns the bus
  int m_rd      = -1;  // slave whose data must show on M_din this cycle

  // Advance the model at each rising edge using the inputs present during the cycle.
  always @(posedge clk) begin
    logic        g_req, g_wr;
    logic [7:0]  g_addr;
    if (!reset_n) begin
      m_owner   = 0;
      m_contend = 0;
      m_rd      = -1;
    end else begin
      g_req  = (m_owner == 1) ? M1_req : M0_req;
      g_wr   = (m_owner == 1) ? M1_wr : M0_wr;
      g_addr = (m_owner == 1) ? M1_address : M0_address;
      m_rd   = (g_req && !g_wr) ? region(g_addr) : -1;
      if (m_owner == 0) begin
        if (!M0_req && M1_req) begin
          m_owner   = 1;
          m_contend = 0;
        end
      end else begin
        if (M0_req) m_contend++;
        if (!M1_req || m_contend >= 16) begin
          m_owner   = 0;
          m_contend = 0;
        end
      end
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    logic        g_req, g_wr;
    logic [7:0]  g_addr;
    logic [31:0] g_dout, e_din;
    if (chk_en) begin
      g_req  = (m_owner == 1) ? M1_req : M0_req;
      g_wr   = (m_owner == 1) ? M1_wr : M0_wr;
      g_addr = (m_owner == 1) ? M1_address : M0_address;
      g_dout = (m_owner == 1) ? M1_dout : M0_dout;
      e_din  = (m_rd == 0) ? S0_dout : (m_rd == 1) ? S1_dout : 32'h0;
      chk1("cmp_M0_grant", M0_grant, m_owner == 0);
      chk1("cmp_M1_grant", M1_grant, m_owner == 1);
      chk1("cmp_S0_sel", S0_sel, g_req && region(g_addr) == 0);
      chk1("cmp_S1_sel", S1_sel, g_req && region(g_addr) == 1);
      chk("cmp_S_address", 32'(S_address), 32'(g_addr));
      chk1("cmp_S_wr", S_wr, g_req && g_wr);
      chk("cmp_S_din", S_din, g_dout);
      chk("cmp_M_din", M_din, e_din);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
    M0_req = req; M0_wr = wr; M0_address = a; M0_dout = d;
  endtask

  task automatic set_m1(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
    M1_req = req; M1_wr = wr; M1_address = a; M1_dout = d;
  endtask

  logic [7:0] bnd_addr [6] = '{8'h1F, 8'h20, 8'h3F, 8'h40, 8'h00, 8'hFF};
  logic [1:0] bnd_sel  [6] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};

  initial begin
    int n;
    reset_n = 1'b0;
    set_m0(0, 0, 8'h00, 32'h0);
    set_m1(0, 0, 8'h00, 32'h0);
    S0_dout = 32'h0;
    S1_dout = 32'h0;
    tick();
    chk_en = 1;
    tick();
    reset_n = 1'b1;
    #1;
    // Reset / idle state.
    chk1("reset_M0_grant", M0_grant, 1'b1);
    chk1("reset_M1_grant", M1_grant, 1'b0);
    chk1("reset_S0_sel", S0_sel, 1'b0);
    chk1("reset_S1_sel", S1_sel, 1'b0);
    chk("reset_M_din", M_din, 32'h0);

    // M1 alone requests for three cycles, then drops.
    set_m1(1, 0, 8'h50, 32'h0);
    #1 chk1("m1req_c1_M1_grant", M1_grant, 1'b0);
    tick(); #1 chk1("m1req_c2_M1_grant", M1_grant, 1'b1);
    tick(); #1 chk1("m1req_c3_M1_grant", M1_grant, 1'b1);
    tick(); M1_req = 0;
    #1 chk1("m1drop_same_cycle_M1_grant", M1_grant, 1'b1);
    tick(); #1 chk1("m1drop_next_M0_grant", M0_grant, 1'b1);

    // M1 owns the bus and reads S1 while M0 keeps asking: tenure ends after 16 contended cycles.
    set_m1(1, 0, 8'h30, 32'h0);
    S1_dout = 32'hCAFE_F00D;
    tick();
    set_m0(1, 0, 8'h90, 32'h0);
    n = 0;
    #1;
    while (M1_grant && n < 40) begin
      n++;
      tick();
      #1;
    end
    chk("hold_contended_cycles", 32'(n), 32'd16);
    chk1("hold_then_M0_grant", M0_grant, 1'b1);
    chk("hold_read_across_grant_change", M_din, 32'hCAFE_F00D);
    tick(); #1 chk1("hold_M0_keeps_bus", M0_grant, 1'b1);
    set_m0(0, 0, 8'h00, 32'h0);
    set_m1(0, 0, 8'h00, 32'h0);
    tick();

    // M1 writes then reads back slave 1 at 0x25.
    set_m1(1, 1, 8'h25, 32'hDEAD_BEEF);
    S1_dout = 32'h0;
    tick(); #1;
    chk1("wr25_S1_sel", S1_sel, 1'b1);
    chk1("wr25_S0_sel", S0_sel, 1'b0);
    chk1("wr25_S_wr", S_wr, 1'b1);
    chk("wr25_S_din", S_din, 32'hDEAD_BEEF);
    chk("wr25_S_address", 32'(S_address), 32'h25);
    tick();
    M1_wr = 0;
    S1_dout = 32'hDEAD_BEEF;
    #1 chk1("rd25_S_wr", S_wr, 1'b0);
    tick();
    set_m1(1, 0, 8'h50, 32'h0);
    #1 chk("rd25_M_din", M_din, 32'hDEAD_BEEF);
    M1_req = 0;
    tick();

    // M0 reads: unmapped, then slave 0.
    tick();
    set_m0(1, 0, 8'h80, 32'h0);
    S0_dout = 32'hAAAA_5555;
    S1_dout = 32'hBBBB_6666;
    #1;
    chk1("rd80_S0_sel", S0_sel, 1'b0);
    chk1("rd80_S1_sel", S1_sel, 1'b0);
    tick();
    set_m0(1, 0, 8'h10, 32'h0);
    S0_dout = 32'h1234_5678;
    #1;
    chk("rd80_M_din", M_din, 32'h0);
    chk1("rd10_S0_sel", S0_sel, 1'b1);
    tick(); #1 chk("rd10_M_din", M_din, 32'h1234_5678);

    // Decode boundaries.
    for (int i = 0; i < 6; i++) begin
      set_m0(1, 0, bnd_addr[i], 32'h0);
      #1 chk("bound_sel", 32'({S1_sel, S0_sel}), 32'(bnd_sel[i]));
      tick();
    end
    // A write never returns data.
    set_m0(1, 1, 8'h10, 32'h7777_0000);
    tick(); #1 chk("wr10_M_din", M_din, 32'h0);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      set_m0((i % 3) != 0, (i % 5) == 0, 8'(i * 29), 32'h1000_0000 + 32'(i));
      set_m1((i % 11) != 10, (i % 4) == 1, 8'(i * 13 + 7), 32'h2000_0000 + 32'(i));
      S0_dout = 32'h5000_0000 + 32'(i);
      S1_dout = 32'h6000_0000 + 32'(i);
      tick();
    end

    // Reset during an M1 read aborts it.
    set_m0(0, 0, 8'h00, 32'h0);
    set_m1(1, 0, 8'h05, 32'h0);
    S0_dout = 32'h1111_2222;
    tick();
    #1 chk1("rst_mid_M1_reading", M1_grant, 1'b1);
    reset_n = 1'b0;
    tick(); #1;
    chk1("rst_mid_M0_grant", M0_grant, 1'b1);
    chk("rst_mid_M_din", M_din, 32'h0);
    reset_n = 1'b1;
    set_m1(0, 0, 8'h00, 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL provide these ports, clock and reset first:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- M0_req  in  1  master 0 (testbench/host) bus request.
- M0_wr  in  1  master 0 write strobe (1 = write, 0 = read).
- M0_address  in  8  master 0 address.
- M0_dout  in  32  master 0 write data.
- M1_req  in  1  master 1 (upstream master block) bus request.
- M1_wr  in  1  master 1 write strobe.
- M1_address  in  8  master 1 address.
- M1_dout  in  32  master 1 write data.
- S0_dout  in  32  slave 0 read data, valid the cycle after its access.
- S1_dout  in  32  slave 1 read data, valid the cycle after its access.
- M0_grant  out  1  bus owned by master 0.
- M1_grant  out  1  bus owned by master 1.
- S0_sel  out  1  slave 0 select.
- S1_sel  out  1  slave 1 select.
- S_address  out  8  address forwarded to slaves.
- S_wr  out  1  write strobe forwarded to slaves.
- S_din  out  32  write data forwarded to slaves.
- M_din  out  32  read data returned to both masters.

Function
REQ-002 Arbiter FSM SHALL have exactly two states, M0_GRANT and M1_GRANT; M0_grant=1 iff state is M0_GRANT, M1_grant=1 iff state is M1_GRANT, never both, never neither.
REQ-003 In M0_GRANT: next state SHALL be M1_GRANT only when M0_req=0 and M1_req=1; otherwise it SHALL remain M0_GRANT.
REQ-004 In M1_GRANT: next state SHALL be M0_GRANT when M1_req=0, or when the hold counter reaches 15 while M0_req=1; otherwise it SHALL remain M1_GRANT.
REQ-005 The 4-bit hold counter SHALL clear on entry to M1_GRANT, increment each cycle in M1_GRANT while M0_req=1, saturate at 15, and clear in M0_GRANT.
REQ-006 Grant changes SHALL take effect one cycle after the request condition is sampled; no combinational request-to-grant path.
REQ-007 S_address, S_wr, S_din SHALL combinationally mux from the currently granted master; S_wr SHALL equal granted master's wr AND req.
REQ-008 Decode of the granted master's address, gated by its req: 0x00-0x1F asserts S0_sel; 0x20-0x3F asserts S1_sel; 0x40-0xFF asserts neither; at most one sel high.
REQ-009 A 2-bit registered read-select SHALL capture {S1_sel,S0_sel} when S_wr=0, else 00; M_din SHALL be S0_dout for 01, S1_dout for 10, 32'h0 otherwise.
REQ-010 Read data therefore SHALL appear on M_din exactly one cycle after the read request cycle, including across a grant change in that cycle.
REQ-011 Unmapped-address access SHALL complete silently: no sel, M_din=0 the next cycle.

Reset
REQ-012 With reset_n=0 at a rising edge: state to M0_GRANT, hold counter to 0, read-select to 00.
REQ-013 Resulting output values after reset: M0_grant=1, M1_grant=0, M_din=0; sel/S_wr follow M0 inputs combinationally.
REQ-014 Reset asserted mid-transfer SHALL abort it; no pending read data is returned after reset.

Structure
REQ-015 State encoding, slave address ranges (0x00, 0x20, 0x40 bounds) and the hold limit 15 SHALL be constants in the shared bus package used by master, slaves and this block.
REQ-016 Address decode SHALL be a separate sub-module named bus_decoder (address, req in; S0_sel, S1_sel out); the arbiter FSM, counter and read mux stay in bus_arbiter.

Verification
REQ-017 Reset, then idle both req=0 -> M0_grant=1, M1_grant=0, S0_sel=S1_sel=0, M_din=0.
REQ-018 M0_req=0, M1_req=1 for 3 cycles -> M1_grant=1 from 2nd cycle; drop M1_req -> M0_grant=1 next cycle.
REQ-019 M1 holds bus, M0_req=1 continuously -> M1_grant drops after 16 cycles of contention and M0_grant=1 on the following cycle.
REQ-020 M1 writes 32'hDEADBEEF to 0x25 -> S1_sel=1, S_wr=1, S_din=DEADBEEF same cycle; next cycle M1 reads 0x25 with S1_dout=DEADBEEF -> M_din=DEADBEEF one cycle later.
REQ-021 M0 reads 0x80 -> no sel asserted, M_din=0 next cycle; M0 reads 0x10 with S0_dout=12345678 -> M_din=12345678 next cycle.
REQ-022 reset_n=0 during an M1 read -> next cycle M0_grant=1, M_din=0.
